// File: rtl/gestor_entradas.sv
// Multi-channel input manager: sync, debounce, round-robin edge events.
// Define GESTOR_ENTRADAS_OVF_EN to build the sticky lost-event flags.
module gestor_entradas #(
   parameter int N_CANAIS        = 4,
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int CNT_W   = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1,
   parameter int CANAL_W = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_CANAIS-1:0] entradas_in,
   output logic [N_CANAIS-1:0] estado_out,
   output logic                evento_valid,
   input  logic                evento_ready,
   output logic [CANAL_W-1:0]  evento_canal,
   output logic                evento_borda,
   output logic [N_CANAIS-1:0] overflow_out,
   input  logic                overflow_clr
);

   typedef enum logic {
      ESTAVEL  = 1'b0,
      CONTANDO = 1'b1
   } estado_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

   logic [N_CANAIS-1:0] sync1;
   logic [N_CANAIS-1:0] x;
   logic [N_CANAIS-1:0] s;
   estado_t             st  [N_CANAIS];
   logic [CNT_W-1:0]    cnt [N_CANAIS];
   logic [N_CANAIS-1:0] toggle;
   logic [N_CANAIS-1:0] pend;
   logic [N_CANAIS-1:0] pend_borda;
   logic [N_CANAIS-1:0] grant;
   logic [CANAL_W-1:0]  ptr;
   logic [CANAL_W-1:0]  sel;
   logic                found;
   logic                load;

   assign estado_out = s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         x     <= '0;
      end else begin
         sync1 <= entradas_in;
         x     <= sync1;
      end
   end

   always_comb begin
      toggle = '0;
      for (int i = 0; i < N_CANAIS; i++) begin
         toggle[i] = (st[i] == CONTANDO) && (x[i] != s[i])
                     && (cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s <= '0;
         for (int i = 0; i < N_CANAIS; i++) begin
            st[i]  <= ESTAVEL;
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CANAIS; i++) begin
            unique case (st[i])
               ESTAVEL: begin
                  cnt[i] <= '0;
                  if (x[i] != s[i]) st[i] <= CONTANDO;
               end
               CONTANDO: begin
                  if (x[i] == s[i]) begin
                     st[i]  <= ESTAVEL;
                     cnt[i] <= '0;
                  end else if (cnt[i] == CNT_MAX) begin
                     s[i]   <= ~s[i];
                     st[i]  <= ESTAVEL;
                     cnt[i] <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + 1'b1;
                  end
               end
               default: begin
                  st[i]  <= ESTAVEL;
                  cnt[i] <= '0;
               end
            endcase
         end
      end
   end

   assign load = !evento_valid || evento_ready;

   // First pending slot after the last grant, wrapping around.
   always_comb begin
      int idx;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int k = 1; k <= N_CANAIS; k++) begin
         idx = (int'(ptr) + k) % N_CANAIS;
         if (!found && pend[idx]) begin
            found = 1'b1;
            sel   = CANAL_W'(idx);
         end
      end
   end

   always_comb begin
      grant = '0;
      if (load && found) grant[sel] = 1'b1;
   end

   // A fresh edge beats a same-cycle grant: the slot stays pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= '0;
         pend_borda <= '0;
      end else begin
         for (int i = 0; i < N_CANAIS; i++) begin
            if (toggle[i]) begin
               pend[i]       <= 1'b1;
               pend_borda[i] <= ~s[i];
            end else if (grant[i]) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evento_valid <= 1'b0;
         evento_canal <= '0;
         evento_borda <= 1'b0;
         ptr          <= CANAL_W'(N_CANAIS - 1);
      end else if (load) begin
         evento_valid <= found;
         if (found) begin
            evento_canal <= sel;
            evento_borda <= pend_borda[sel];
            ptr          <= sel;
         end
      end
   end

`ifdef GESTOR_ENTRADAS_OVF_EN
   logic [N_CANAIS-1:0] ovf;
   logic [N_CANAIS-1:0] ovf_set;

   assign ovf_set = toggle & pend & ~grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf <= '0;
      else        ovf <= (overflow_clr ? '0 : ovf) | ovf_set;
   end

   assign overflow_out = ovf;
`else
   logic unused_clr;
   assign unused_clr   = overflow_clr;
   assign overflow_out = '0;
`endif

endmodule

// File: tb/tb_gestor_entradas.sv
// Bench for gestor_entradas: directed steps plus random pins/ready,
// checked each cycle against an edge-level behavioural model.
module tb_gestor_entradas;

   localparam int N = 4;
   localparam int D = 4;
`ifdef GESTOR_ENTRADAS_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] entradas = '0;
   logic [N-1:0] estado_out;
   logic         evento_valid;
   logic         evento_ready = 1'b1;
   logic [1:0]   evento_canal;
   logic         evento_borda;
   logic [N-1:0] overflow_out;
   logic         overflow_clr = 1'b0;

   int errors = 0;
   int checks = 0;

   gestor_entradas #(
      .N_CANAIS(N),
      .DEBOUNCE_CICLOS(D)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .entradas_in(entradas),
      .estado_out(estado_out),
      .evento_valid(evento_valid),
      .evento_ready(evento_ready),
      .evento_canal(evento_canal),
      .evento_borda(evento_borda),
      .overflow_out(overflow_out),
      .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   // Reference model: pins reach the debouncer two edges late; a level
   // is accepted after D+1 consecutive mismatching samples.
   logic [N-1:0] smp1, smp2, m_s, m_pend, m_pb, m_ovf;
   int           run [N];
   bit           m_valid, m_borda;
   int           m_canal, m_ptr;

   function automatic void m_reset();
      smp1 = '0; smp2 = '0; m_s = '0;
      m_pend = '0; m_pb = '0; m_ovf = '0;
      m_valid = 0; m_borda = 0; m_canal = 0;
      m_ptr = N - 1;
      for (int i = 0; i < N; i++) run[i] = 0;
   endfunction

   function automatic void m_edge();
      logic [N-1:0] xs, granted, setv;
      bit f;
      int c, nptr;
      xs = smp2; smp2 = smp1; smp1 = entradas;
      granted = '0; setv = '0; nptr = m_ptr;
      if (!m_valid || evento_ready) begin
         m_valid = 0; f = 0;
         for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (!f && m_pend[c]) begin
               f = 1; m_valid = 1; m_canal = c;
               m_borda = m_pb[c]; granted[c] = 1'b1; nptr = c;
            end
         end
      end
      m_ptr = nptr;
      m_pend &= ~granted;
      for (int i = 0; i < N; i++) begin
         if (xs[i] != m_s[i]) begin
            run[i]++;
            if (run[i] == D + 1) begin
               run[i] = 0;
               m_s[i] = ~m_s[i];
               if (m_pend[i]) setv[i] = 1'b1;
               m_pend[i] = 1'b1;
               m_pb[i] = m_s[i];
            end
         end else begin
            run[i] = 0;
         end
      end
      if (overflow_clr) m_ovf = '0;
      m_ovf |= setv;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("estado", 32'(estado_out), 32'(m_s));
      chk("valid", 32'(evento_valid), 32'(m_valid));
      if (m_valid) begin
         chk("canal", 32'(evento_canal), 32'(m_canal));
         chk("borda", 32'(evento_borda), 32'(m_borda));
      end
      chk("overflow", 32'(overflow_out), OVF_EN ? 32'(m_ovf) : 32'd0);
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_estado"}, 32'(estado_out), 0);
      chk({tag, "_valid"}, 32'(evento_valid), 0);
      chk({tag, "_canal"}, 32'(evento_canal), 0);
      chk({tag, "_borda"}, 32'(evento_borda), 0);
      chk({tag, "_ovf"}, 32'(overflow_out), 0);
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         m_edge();
         #1;
         check_all();
      end
   endtask

   task automatic rst_step(int n);
      repeat (n) begin
         @(posedge clk);
         m_reset();
         #1;
         check_zero("rst");
      end
   endtask

   initial begin
      m_reset();
      #1 rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         entradas = N'($urandom);
         rst_step(1);
      end
      entradas = '0;
      rst_n = 1'b1;
      step(3);

      // first debounced rise on channel 0
      entradas[0] = 1'b1;
      step(6);
      chk("rise_early", 32'(estado_out[0]), 0);
      step(1);
      chk("rise_estado", 32'(estado_out[0]), 1);
      chk("rise_novalid", 32'(evento_valid), 0);
      step(1);
      chk("rise_valid", 32'(evento_valid), 1);
      chk("rise_canal", 32'(evento_canal), 0);
      chk("rise_borda", 32'(evento_borda), 1);

      // glitch on channel 1
      entradas[1] = 1'b1;
      step(3);
      entradas[1] = 1'b0;
      step(10);
      chk("glitch_estado", 32'(estado_out[1]), 0);
      chk("glitch_valid", 32'(evento_valid), 0);

      // settle, reset so channel 0 has first priority
      entradas = '0;
      step(12);
      rst_n = 1'b0;
      m_reset();
      #1 check_zero("rr_rst");
      rst_step(1);
      rst_n = 1'b1;
      step(2);

      entradas ^= 4'b1101;
      step(7);
      chk("rr_estado", 32'(estado_out), 32'b1101);
      step(1);
      chk("rr1_canal", 32'(evento_canal), 0);
      step(1);
      chk("rr2_canal", 32'(evento_canal), 2);
      step(1);
      chk("rr3_canal", 32'(evento_canal), 3);
      step(1);
      chk("rr_drained", 32'(evento_valid), 0);
      entradas ^= 4'b1001;
      step(8);
      chk("rr4_canal", 32'(evento_canal), 0);
      step(1);
      chk("rr5_canal", 32'(evento_canal), 3);
      chk("rr5_borda", 32'(evento_borda), 0);
      step(1);

      // backpressure while channel 1 rises then falls
      evento_ready = 1'b0;
      entradas[0] = 1'b1;
      step(8);
      chk("bp_valid", 32'(evento_valid), 1);
      for (int i = 0; i < 20; i++) begin
         if (i == 0) entradas[1] = 1'b1;
         if (i == 8) entradas[1] = 1'b0;
         step(1);
         chk("bp_hold_canal", 32'(evento_canal), 0);
         chk("bp_hold_borda", 32'(evento_borda), 1);
      end
      chk("bp_ovf", 32'(overflow_out[1]), 32'(OVF_EN));
      evento_ready = 1'b1;
      step(1);
      chk("bp_next_valid", 32'(evento_valid), 1);
      chk("bp_next_canal", 32'(evento_canal), 1);
      chk("bp_next_borda", 32'(evento_borda), 0);
      step(1);
      chk("bp_drained", 32'(evento_valid), 0);

      // overflow clear, then clear coinciding with an overwrite
      overflow_clr = 1'b1;
      step(1);
      overflow_clr = 1'b0;
      chk("clr_ovf", 32'(overflow_out), 0);
      evento_ready = 1'b0;
      entradas[2] = ~entradas[2];
      step(9);
      chk("ovf_hold_canal", 32'(evento_canal), 2);
      entradas[3] = 1'b1;
      step(9);
      entradas[3] = 1'b0;
      step(6);
      overflow_clr = 1'b1;
      step(1);
      overflow_clr = 1'b0;
      chk("clr_vs_set", 32'(overflow_out[3]), 32'(OVF_EN));
      step(1);
      chk("ovf_sticky", 32'(overflow_out[3]), 32'(OVF_EN));
      evento_ready = 1'b1;
      step(4);

      // random pins, ready and clear
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) entradas = N'($urandom);
         evento_ready = ($urandom_range(0, 3) != 0);
         overflow_clr = ($urandom_range(0, 15) == 0);
         step(1);
      end
      entradas = '0;
      evento_ready = 1'b1;
      overflow_clr = 1'b0;
      step(15);

      // reset while channel 2 is mid-count
      entradas[2] = 1'b1;
      step(5);
      rst_n = 1'b0;
      m_reset();
      #1 check_zero("midrst");
      entradas[2] = 1'b0;
      rst_step(3);
      rst_n = 1'b1;
      step(12);
      chk("midrst_estado", 32'(estado_out[2]), 0);
      chk("midrst_valid", 32'(evento_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
